// File: rtl/hazard_ctrl_unit.sv
// Hazard control for the 5-stage RV32 pipeline: forwarding, load-use stall, branch flush, memory-wait FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 64,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [REG_AW-1:0] RD_M,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              StallW,
  output logic              FlushD,
  output logic              FlushE,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  lu_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  mem_wait_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;
  localparam logic [TO_W-1:0]   WAIT_MAX = '1;
  localparam logic [TO_W-1:0]   WAIT_ONE = TO_W'(1);
  localparam logic [TO_W:0]     TO_LIMIT = (TO_W+1)'(MEM_TIMEOUT);

  // M stage result is younger than W, so it wins when both match
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != ZERO_REG) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != ZERO_REG) && (rd_w == rs)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TO_W-1:0] r_wait_cnt;
  logic [TO_W-1:0] w_wait_nxt;
  logic            r_mem_timeout;
  logic            w_mem_stall;
  logic            w_lu;

  always_comb begin
    w_mem_stall = 1'b0;
    w_lu        = 1'b0;
    w_mem_stall = !MemReadyM && (MemReqM || (r_state == ST_MEM_WAIT));
    w_lu        = ResultSrcE && (RD_E != ZERO_REG) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (MemReqM && !MemReadyM) begin
          w_state_nxt = ST_MEM_WAIT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (MemReadyM) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_MEM_WAIT;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Count only cycles spent waiting in MEM_WAIT; the entry cycle restarts the count
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if ((r_state == ST_RUN) && (w_state_nxt == ST_MEM_WAIT)) begin
      w_wait_nxt = '0;
    end else if ((r_state == ST_MEM_WAIT) && !MemReadyM && (r_wait_cnt != WAIT_MAX)) begin
      w_wait_nxt = r_wait_cnt + WAIT_ONE;
    end else begin
      w_wait_nxt = r_wait_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_mem_timeout <= r_mem_timeout | ({1'b0, w_wait_nxt} >= TO_LIMIT);
    end
  end

  assign mem_timeout = r_mem_timeout;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    if (!rst) begin
      ForwardAE = fwd_sel(Rs1_E, RegWriteM, RD_M, RegWriteW, RD_W);
      ForwardBE = fwd_sel(Rs2_E, RegWriteM, RD_M, RegWriteW, RD_W);
      // A branch seen while frozen stays in E and flushes once the wait ends
      if (w_mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (w_lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        FlushD = 1'b0;
        FlushE = 1'b0;
      end
    end else begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic             w_lu_win;
  logic             w_flush_win;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_mw_cnt;

  assign w_flush_win = !w_mem_stall && PCSrcE;
  assign w_lu_win    = !w_mem_stall && !PCSrcE && w_lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_cnt    <= '0;
      r_flush_cnt <= '0;
      r_mw_cnt    <= '0;
    end else begin
      r_lu_cnt    <= sat_inc(r_lu_cnt, w_lu_win);
      r_flush_cnt <= sat_inc(r_flush_cnt, w_flush_win);
      r_mw_cnt    <= sat_inc(r_mw_cnt, w_mem_stall);
    end
  end

  assign lu_stall_cnt = r_lu_cnt;
  assign flush_cnt    = r_flush_cnt;
  assign mem_wait_cnt = r_mw_cnt;
`else
  assign lu_stall_cnt = '0;
  assign flush_cnt    = '0;
  assign mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed plus randomized bench for hazard_ctrl_unit, checked against a cycle-level behavioural model.
module tb_hazard_ctrl_unit;

  localparam int MEM_TO = 4;
  localparam int CNT_MAXV = 65535;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, mem_timeout;
  logic [15:0] lu_stall_cnt, flush_cnt, mem_wait_cnt;

  hazard_ctrl_unit #(.REG_AW(5), .MEM_TIMEOUT(MEM_TO), .TO_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .mem_timeout(mem_timeout),
    .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .mem_wait_cnt(mem_wait_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: a memory stall streak is a run of consecutive stalled cycles
  bit m_prev_stall;
  int m_streak;
  bit m_to;
  int m_lu, m_fl, m_mw;

  logic [1:0] e_fa, e_fb;
  logic e_sf, e_sd, e_se, e_sm, e_sw, e_fd, e_fe;
  bit c_lu, c_fl, c_mw;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (RegWriteM && RD_M == rs) return 2'b10;
    if (RegWriteW && RD_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_comb();
    bit mem, lu;
    {e_fa, e_fb} = 4'b0000;
    {e_sf, e_sd, e_se, e_sm, e_sw, e_fd, e_fe} = 7'b0000000;
    c_lu = 1'b0; c_fl = 1'b0; c_mw = 1'b0;
    if (!rst) begin
      e_fa = m_fwd(Rs1_E);
      e_fb = m_fwd(Rs2_E);
      mem = !MemReadyM && (MemReqM || m_prev_stall);
      lu  = ResultSrcE && RD_E != 5'd0 && (RD_E == Rs1_D || RD_E == Rs2_D);
      if (mem) begin
        {e_sf, e_sd, e_se, e_sm, e_sw} = 5'b11111;
        c_mw = 1'b1;
      end else if (PCSrcE) begin
        {e_fd, e_fe} = 2'b11;
        c_fl = 1'b1;
      end else if (lu) begin
        {e_sf, e_sd, e_fe} = 3'b111;
        c_lu = 1'b1;
      end
    end
  endtask

  task automatic settle_check();
    #1;
    model_comb();
    chk("ForwardAE", 32'(ForwardAE), 32'(e_fa));
    chk("ForwardBE", 32'(ForwardBE), 32'(e_fb));
    chk("StallF", 32'(StallF), 32'(e_sf));
    chk("StallD", 32'(StallD), 32'(e_sd));
    chk("StallE", 32'(StallE), 32'(e_se));
    chk("StallM", 32'(StallM), 32'(e_sm));
    chk("StallW", 32'(StallW), 32'(e_sw));
    chk("FlushD", 32'(FlushD), 32'(e_fd));
    chk("FlushE", 32'(FlushE), 32'(e_fe));
    chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_stall_cnt", 32'(lu_stall_cnt), 32'(m_lu));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_fl));
    chk("mem_wait_cnt", 32'(mem_wait_cnt), 32'(m_mw));
`else
    chk("lu_stall_cnt", 32'(lu_stall_cnt), 32'd0);
    chk("flush_cnt", 32'(flush_cnt), 32'd0);
    chk("mem_wait_cnt", 32'(mem_wait_cnt), 32'd0);
`endif
  endtask

  task automatic tick();
    model_comb();
    @(posedge clk);
    if (rst) begin
      m_prev_stall = 1'b0; m_streak = 0; m_to = 1'b0;
      m_lu = 0; m_fl = 0; m_mw = 0;
    end else begin
      if (c_lu && m_lu < CNT_MAXV) m_lu++;
      if (c_fl && m_fl < CNT_MAXV) m_fl++;
      if (c_mw && m_mw < CNT_MAXV) m_mw++;
      // The first stalled cycle is the request cycle; timeout after MEM_TO further waits
      if (c_mw) m_streak++;
      else m_streak = 0;
      if (m_streak > MEM_TO) m_to = 1'b1;
      m_prev_stall = c_mw;
    end
    #1;
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  task automatic idle_inputs();
    rst = 1'b0;
    {Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W} = '0;
    {ResultSrcE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM} = 6'b000000;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    // Reset with every hazard source active: all outputs must be low
    Rs1_E = 5'd5; RD_M = 5'd5; RegWriteM = 1'b1; PCSrcE = 1'b1; MemReqM = 1'b1;
    settle_check();
    chk("rst_fwdA", 32'(ForwardAE), 32'd0);
    chk("rst_flushD", 32'(FlushD), 32'd0);
    tick();
    idle_inputs();
    step();

    // Forwarding priority and x0 exclusion
    Rs1_E = 5'd5; Rs2_E = 5'd5; RD_M = 5'd5; RegWriteM = 1'b1; RD_W = 5'd5; RegWriteW = 1'b1;
    settle_check();
    chk("fwd_M_prio", 32'(ForwardAE), 32'd2);
    tick();
    RegWriteM = 1'b0;
    settle_check();
    chk("fwd_W", 32'(ForwardBE), 32'd1);
    tick();
    RegWriteM = 1'b1; Rs1_E = 5'd0; Rs2_E = 5'd0; RD_M = 5'd0; RD_W = 5'd0;
    settle_check();
    chk("fwd_x0", 32'(ForwardAE), 32'd0);
    tick();
    idle_inputs();

    // Load-use: one stall cycle, then E holds a bubble
    ResultSrcE = 1'b1; RD_E = 5'd7; Rs2_D = 5'd7;
    settle_check();
    chk("lu_stallD", 32'(StallD), 32'd1);
    chk("lu_flushE", 32'(FlushE), 32'd1);
    tick();
    ResultSrcE = 1'b0; RD_E = 5'd0;
    settle_check();
    chk("lu_release", 32'(StallF), 32'd0);
    tick();

    // Branch wins over a coincident load-use
    ResultSrcE = 1'b1; RD_E = 5'd3; Rs1_D = 5'd3; PCSrcE = 1'b1;
    settle_check();
    chk("br_flushD", 32'(FlushD), 32'd1);
    chk("br_stallF", 32'(StallF), 32'd0);
    tick();
    idle_inputs();
    step();

    // Three-cycle memory wait
    MemReqM = 1'b1;
    repeat (3) step();
    MemReadyM = 1'b1;
    settle_check();
    chk("mw_release", 32'(StallW), 32'd0);
    tick();
    idle_inputs();
    settle_check();
    chk("mw_run_state", 32'(StallF), 32'd0);
    tick();

    // Timeout after a long wait; sticky until reset
    MemReqM = 1'b1;
    repeat (4) step();
    settle_check();
    chk("to_before", 32'(mem_timeout), 32'd0);
    tick();
    settle_check();
    chk("to_set", 32'(mem_timeout), 32'd1);
    chk("to_still_stalled", 32'(StallM), 32'd1);
    tick();
    repeat (4) step();
    MemReadyM = 1'b1;
    step();
    idle_inputs();
    settle_check();
    chk("to_sticky", 32'(mem_timeout), 32'd1);
    tick();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle_check();
    chk("to_cleared", 32'(mem_timeout), 32'd0);
    tick();

    // Branch held across a two-cycle wait flushes on release
    MemReqM = 1'b1; PCSrcE = 1'b1;
    settle_check();
    chk("brw_noflush", 32'(FlushE), 32'd0);
    tick();
    step();
    MemReadyM = 1'b1;
    settle_check();
    chk("brw_flush", 32'(FlushD), 32'd1);
    tick();
    idle_inputs();
    step();

    // Reset mid-wait returns to RUN; pending request re-enters wait
    MemReqM = 1'b1;
    step();
    step();
    rst = 1'b1;
    settle_check();
    chk("rst_mid_stall", 32'(StallF), 32'd0);
    tick();
    rst = 1'b0; MemReqM = 1'b0;
    settle_check();
    chk("rst_run_state", 32'(StallE), 32'd0);
    tick();
    MemReqM = 1'b1;
    step();
    step();
    MemReadyM = 1'b1;
    step();
    idle_inputs();
    step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 59) == 0);
      Rs1_D      = 5'($urandom_range(0, 3));
      Rs2_D      = 5'($urandom_range(0, 3));
      Rs1_E      = 5'($urandom_range(0, 3));
      Rs2_E      = 5'($urandom_range(0, 3));
      RD_E       = 5'($urandom_range(0, 3));
      RD_M       = 5'($urandom_range(0, 3));
      RD_W       = 5'($urandom_range(0, 3));
      ResultSrcE = ($urandom_range(0, 3) == 0);
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      PCSrcE     = ($urandom_range(0, 5) == 0);
      MemReqM    = ($urandom_range(0, 2) == 0);
      MemReadyM  = (i % 200 > 150) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
